stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Run/pause/clear controller for the team's 16-bit prescaled hex counter datapath: sequences counting from operator button pulses, applies a 4-bit prescaler, stops or reloads at a programmable terminal value, and captures lap values. It sits between the debounced button inputs and the seven-segment display path and owns the count register.

## Interface

- WIDTH, 16, width of count, limit and lap_value
- PRE_W, 4, width of prescaler setting max
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state on the next rising edge
- start  in  1  single-cycle pulse: start or resume counting
- stop  in  1  single-cycle pulse: pause counting
- clear  in  1  single-cycle pulse: zero everything, return to IDLE
- lap  in  1  single-cycle pulse: capture current count into lap_value
- auto_reload  in  1  1 = wrap to 0 at limit and keep running; 0 = one-shot
- max  in  PRE_W  prescaler setting; count advances once per max+1 RUN cycles
- limit  in  WIDTH  terminal count value
- count  out  WIDTH  current count; reset 0
- lap_value  out  WIDTH  last captured count; reset 0
- running  out  1  1 while in RUN; reset 0
- tick  out  1  combinational: RUN and prescaler ≥ max; reset 0
- done  out  1  registered one-cycle pulse after terminal tick; reset 0

## Operation

- States: IDLE, RUN, PAUSE, DONE. Reset → IDLE, count = pre = lap_value = 0, done = 0.
- Command priority within a cycle: clear > stop > start. lap is independent and is honoured alongside any of them.
- IDLE: start → RUN with pre = 0 and count = 0.
- RUN: stop → PAUSE, with pre and count held. clear → IDLE, zeroing everything. start is ignored.
- PAUSE: start → RUN; pre and count resume from their held values. clear → IDLE.
- DONE: start → RUN with count = 0 and pre = 0. clear → IDLE. stop is ignored.
- Prescaler in RUN:
  - if pre ≥ max: tick = 1 and pre ← 0;
  - else pre ← pre + 1.
  - The ≥ compare means that lowering max mid-run below pre produces a tick in the same cycle.
- On tick:
  - if count == limit and auto_reload = 1: count ← 0, done pulse, stay in RUN;
  - if count == limit and auto_reload = 0: count holds, done pulse, → DONE;
  - else count ← count + 1, with modulo 2^WIDTH wrap (0xFFFF → 0x0000 when limit has not been reached, which is only possible if limit was lowered below count mid-run).
- limit = 0: terminal on the first tick.
- lap stores the count value present in that cycle, i.e. before the same-edge increment. A lap together with clear stores the pre-clear count, and clear then zeroes count but not that capture.
- A stop in the same cycle as a tick: the tick's count update still occurs; the state then becomes PAUSE.
- A clear in the same cycle as a tick: clear wins, count = 0, no done pulse.
- reset asserted mid-operation: identical to power-up reset, with no done pulse.

## Timing

- start sampled at edge N → running = 1 from cycle N+1, with pre = 0 in N+1.
- The count reaches k after exactly k·(max+1) RUN cycles. With max = 0 the count increments every RUN cycle.
- done is high for exactly one cycle, the cycle after the terminal tick.
- stop at edge M → running = 0 from M+1, with no further count changes.
- lap_value updates at the edge that samples lap (1-cycle latency).

## Structure

- Package stopwatch_pkg holds the state encoding constants (IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3) and the default WIDTH/PRE_W constants.
- One sub-module, stopwatch_prescaler:
  - inputs: clk, reset, en, zero, max;
  - outputs: tick;
  - holds the pre register.
- The FSM, count, lap and done logic stay in stopwatch_ctrl.

## Test plan

- max = 0, limit = 5, auto_reload = 0; start pulse → count 1,2,3,4,5 on consecutive cycles, then done pulses once, running = 0, count holds at 5.
- max = 3, limit = 0xFFFF; start, then stop after 10 cycles → count = 2, held for 20 cycles; start again → next increment occurs 2 cycles later (pre resumes from 2).
- max = 0, limit = 2, auto_reload = 1 → count sequence 1,2,0,1,2,0; done pulses each time count goes 2→0; running stays 1.
- During RUN with count = 7, assert lap and clear in the same cycle → lap_value = 7, count = 0, state IDLE, no done pulse.
- Assert start, stop and clear together while in RUN → IDLE, count = 0; assert start and stop together in PAUSE → stays PAUSE.
- Assert reset mid-run with count = 0x1234 → next cycle all outputs are 0 and the state is IDLE; the first start after reset counts from 0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch controller: state encoding and default widths.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package stopwatch_pkg;

  localparam int SW_WIDTH = 16;
  localparam int SW_PRE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } sw_state_t;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Operator command / configuration / status bundle of the stopwatch controller.
// Latency: n/a (wires only).
// Backpressure: none; commands are single-cycle pulses, always accepted.
interface stopwatch_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int PRE_W = 4
);
  logic             start;
  logic             stop;
  logic             clear;
  logic             lap;
  logic             auto_reload;
  logic [PRE_W-1:0] max;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] lap_value;
  logic             running;
  logic             tick;
  logic             done;

  // Button/config side: drives commands, observes status.
  modport master (
    output start, stop, clear, lap, auto_reload, max, limit,
    input  count, lap_value, running, tick, done
  );

  // Controller side.
  modport slave (
    input  start, stop, clear, lap, auto_reload, max, limit,
    output count, lap_value, running, tick, done
  );
endinterface

// File: rtl/stopwatch_prescaler.sv
// Prescaler: asserts tick once every max+1 enabled cycles; owns the pre register.
// Latency: tick is combinational from pre/max; pre updates on the next edge.
// Backpressure: none; while en is low pre holds, zero forces it back to 0.
module stopwatch_prescaler
  import stopwatch_pkg::*;
#(
  parameter int PRE_W = SW_PRE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             zero,
  input  logic [PRE_W-1:0] max,
  output logic             tick
);

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;

  // >= rather than == so that lowering max below pre ticks immediately
  // instead of running pre all the way round.
  always_comb begin
    tick  = 1'b0;
    pre_d = pre_q;
    if (en && (pre_q >= max)) begin
      tick = 1'b1;
    end
    if (zero) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
    end
  end

  // Prescale count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear stopwatch: FSM, prescaled count, terminal detect, lap capture.
// Latency: commands act at the sampling edge; done pulses the cycle after the terminal tick.
// Backpressure: none; command priority clear > stop > start, lap independent.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int WIDTH = SW_WIDTH,
  parameter int PRE_W = SW_PRE_W
) (
  input logic                  clk,
  input logic                  reset,
  stopwatch_ctrl_if.slave      bus
);

  sw_state_t        state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] lap_q,   lap_d;
  logic             done_q,  done_d;
  logic             tick;
  logic             run_en;
  logic             pre_zero;

  assign run_en   = (state_q == RUN);
  // Pre restarts from 0 whenever counting restarts from scratch; PAUSE keeps it.
  assign pre_zero = bus.clear || (state_q == IDLE) || (state_q == DONE);

  stopwatch_prescaler #(.PRE_W(PRE_W)) u_pre (
    .clk   (clk),
    .reset (reset),
    .en    (run_en),
    .zero  (pre_zero),
    .max   (bus.max),
    .tick  (tick)
  );

  // Next state, count, lap and done; clear is applied last so it overrides everything.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lap_d   = lap_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          count_d = '0;
        end
      end
      RUN: begin
        // A tick in the stop cycle still updates count; stop only picks the next state.
        if (tick) begin
          if (count_q == bus.limit) begin
            done_d = 1'b1;
            if (bus.auto_reload) begin
              count_d = '0;
            end else begin
              state_d = DONE;
            end
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        if (bus.stop) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (bus.start && !bus.stop) begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_d = RUN;
          count_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.clear) begin
      state_d = IDLE;
      count_d = '0;
      done_d  = 1'b0;
    end

    // Lap captures the pre-edge count, even when clear zeroes it this edge.
    if (bus.lap) begin
      lap_d = count_q;
    end else if (bus.clear) begin
      lap_d = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      lap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lap_q   <= lap_d;
      done_q  <= done_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.lap_value = lap_q;
  assign bus.running   = run_en;
  assign bus.tick      = tick;
  assign bus.done      = done_q;

endmodule
